// File: rtl/ghost_scheduler_pkg.sv
// ghost_pkg: shared constants for the ghost scheduler.
// Holds direction encodings, grid size, FSM state encoding, the scatter
// corner constants and the wall-map index helper.
package ghost_pkg;

  // Path finder direction encoding
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Playfield geometry
  localparam int GRID_W   = 18;
  localparam int GRID_H   = 5;
  localparam int MAP_BITS = GRID_W * GRID_H;
  localparam logic [4:0] MAX_X = 5'd17;
  localparam logic [4:0] MAX_Y = 5'd4;

  // Sweep FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_MOVE   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Scatter corners: index 0 (0,0), 1 (17,0), 2 (0,4), 3 (17,4)
  localparam logic [4:0] CORNER_X_LO = 5'd0;
  localparam logic [4:0] CORNER_X_HI = 5'd17;
  localparam logic [4:0] CORNER_Y_LO = 5'd0;
  localparam logic [4:0] CORNER_Y_HI = 5'd4;

  function automatic logic [4:0] corner_x(input logic [1:0] sel);
    return sel[0] ? CORNER_X_HI : CORNER_X_LO;
  endfunction

  function automatic logic [4:0] corner_y(input logic [1:0] sel);
    return sel[1] ? CORNER_Y_HI : CORNER_Y_LO;
  endfunction

  // Wall-map bit index x + 18*y, evaluated at 7 bits (max 89)
  function automatic logic [6:0] map_index(input logic [4:0] x, input logic [4:0] y);
    return {2'b00, x} + (7'd18 * {2'b00, y});
  endfunction

endpackage

// File: rtl/ghost_scheduler_if.sv
// ghost_scheduler_if: link between the scheduler and the shared
// combinational path finder. The scheduler (master) drives the current and
// target cells; the path finder (slave) answers with a direction.
interface ghost_scheduler_if;
  logic [4:0] path_cur_x;
  logic [4:0] path_cur_y;
  logic [4:0] path_tgt_x;
  logic [4:0] path_tgt_y;
  logic [1:0] path_dir;

  modport master (
    output path_cur_x, path_cur_y, path_tgt_x, path_tgt_y,
    input  path_dir
  );

  modport slave (
    input  path_cur_x, path_cur_y, path_tgt_x, path_tgt_y,
    output path_dir
  );
endinterface

// File: rtl/ghost_scheduler_step.sv
// ghost_step: combinational single-cell move of one ghost.
// The ghost stays put when it already sits on its target, when the step
// would leave the 18x5 grid (checked before any add/subtract so no 5-bit
// wrap can occur), or when the destination cell is a wall.
module ghost_step
  import ghost_pkg::*;
(
  input  logic [4:0]  x,
  input  logic [4:0]  y,
  input  logic [1:0]  dir,
  input  logic [4:0]  tgt_x,
  input  logic [4:0]  tgt_y,
  input  logic [0:89] map,
  output logic [4:0]  next_x,
  output logic [4:0]  next_y
);

  logic       at_target;
  logic       in_bounds;
  logic       wall;
  logic [4:0] dest_x;
  logic [4:0] dest_y;
  logic [6:0] dest_idx;

  // Decide the destination cell and whether the ghost may enter it
  always_comb begin
    at_target = (x == tgt_x) && (y == tgt_y);
    dest_x    = x;
    dest_y    = y;
    in_bounds = 1'b0;
    case (dir)
      DIR_UP: begin
        if (y != 5'd0) begin
          in_bounds = 1'b1;
          dest_y    = y - 5'd1;
        end else begin
          in_bounds = 1'b0;
        end
      end
      DIR_DOWN: begin
        if (y < MAX_Y) begin
          in_bounds = 1'b1;
          dest_y    = y + 5'd1;
        end else begin
          in_bounds = 1'b0;
        end
      end
      DIR_LEFT: begin
        if (x != 5'd0) begin
          in_bounds = 1'b1;
          dest_x    = x - 5'd1;
        end else begin
          in_bounds = 1'b0;
        end
      end
      DIR_RIGHT: begin
        if (x < MAX_X) begin
          in_bounds = 1'b1;
          dest_x    = x + 5'd1;
        end else begin
          in_bounds = 1'b0;
        end
      end
      default: begin
        in_bounds = 1'b0;
      end
    endcase
    dest_idx = map_index(dest_x, dest_y);
    // An index past the map can only come from a corrupted position; treat it as a wall
    if (dest_idx < 7'd90) begin
      wall = map[dest_idx];
    end else begin
      wall = 1'b1;
    end
    if (!at_target && in_bounds && !wall) begin
      next_x = dest_x;
      next_y = dest_y;
    end else begin
      next_x = x;
      next_y = y;
    end
  end

endmodule

// File: rtl/ghost_scheduler.sv
// ghost_scheduler: time-multiplexes one shortest-path direction finder over
// NUM_GHOSTS ghosts. Each move_tick starts a sweep that serves the ghosts in
// index order (ISSUE -> SAMPLE -> MOVE per ghost) and then pulses sweep_done.
// Owns all ghost positions and the sticky caught flag.
// Optional feature macro: GHOST_SCATTER_EN adds scatter_mode, which sends
// each ghost to a corner chosen by its index instead of chasing pacman.
module ghost_scheduler
  import ghost_pkg::*;
#(
  parameter int NUM_GHOSTS = 4,
  parameter int HOME_X     = 7,
  parameter int HOME_Y     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    move_tick,
  input  logic [0:89]             map,
  input  logic [4:0]              pac_x,
  input  logic [4:0]              pac_y,
`ifdef GHOST_SCATTER_EN
  input  logic                    scatter_mode,
`endif
  ghost_scheduler_if.master       path,
  output logic [5*NUM_GHOSTS-1:0] ghost_x,
  output logic [5*NUM_GHOSTS-1:0] ghost_y,
  output logic                    busy,
  output logic                    sweep_done,
  output logic                    caught,
  input  logic                    clear_caught
);

  logic [2:0] state;
  logic [2:0] idx;
  logic [2:0] nxt_idx;
  logic [4:0] pac_lx;
  logic [4:0] pac_ly;
  logic [1:0] dir;
  logic [4:0] cur_x;
  logic [4:0] cur_y;
  logic [4:0] tgt_x;
  logic [4:0] tgt_y;
  logic [4:0] gx [NUM_GHOSTS];
  logic [4:0] gy [NUM_GHOSTS];

  logic [4:0] sel_x;
  logic [4:0] sel_y;
  logic [4:0] load_x;
  logic [4:0] load_y;
  logic [4:0] start_tx;
  logic [4:0] start_ty;
  logic [4:0] next_tx;
  logic [4:0] next_ty;
  logic [4:0] step_x;
  logic [4:0] step_y;

`ifdef GHOST_SCATTER_EN
  logic scatter_l;
`endif

  assign path.path_cur_x = cur_x;
  assign path.path_cur_y = cur_y;
  assign path.path_tgt_x = tgt_x;
  assign path.path_tgt_y = tgt_y;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_pack
    assign ghost_x[5*g +: 5] = gx[g];
    assign ghost_y[5*g +: 5] = gy[g];
  end

  assign nxt_idx = idx + 3'd1;

  // Select the ghost being moved and the ghost to be loaded next
  always_comb begin
    sel_x  = gx[0];
    sel_y  = gy[0];
    load_x = gx[0];
    load_y = gy[0];
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      sel_x  = (idx == 3'(i))     ? gx[i] : sel_x;
      sel_y  = (idx == 3'(i))     ? gy[i] : sel_y;
      load_x = (nxt_idx == 3'(i)) ? gx[i] : load_x;
      load_y = (nxt_idx == 3'(i)) ? gy[i] : load_y;
    end
  end

  // Targets for ghost 0 at sweep start and for the next ghost in the sweep
  always_comb begin
`ifdef GHOST_SCATTER_EN
    if (scatter_mode) begin
      start_tx = corner_x(2'b00);
      start_ty = corner_y(2'b00);
    end else begin
      start_tx = pac_x;
      start_ty = pac_y;
    end
    if (scatter_l) begin
      next_tx = corner_x(nxt_idx[1:0]);
      next_ty = corner_y(nxt_idx[1:0]);
    end else begin
      next_tx = pac_lx;
      next_ty = pac_ly;
    end
`else
    start_tx = pac_x;
    start_ty = pac_y;
    next_tx  = pac_lx;
    next_ty  = pac_ly;
`endif
  end

  ghost_step u_step (
    .x      (sel_x),
    .y      (sel_y),
    .dir    (dir),
    .tgt_x  (tgt_x),
    .tgt_y  (tgt_y),
    .map    (map),
    .next_x (step_x),
    .next_y (step_y)
  );

  // Sweep sequencing: FSM, ghost index, latched pacman and path finder inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= 3'd0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      pac_lx     <= 5'd0;
      pac_ly     <= 5'd0;
      dir        <= 2'b00;
      cur_x      <= 5'd0;
      cur_y      <= 5'd0;
      tgt_x      <= 5'd0;
      tgt_y      <= 5'd0;
`ifdef GHOST_SCATTER_EN
      scatter_l  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          sweep_done <= 1'b0;
          if (move_tick) begin
            pac_lx    <= pac_x;
            pac_ly    <= pac_y;
`ifdef GHOST_SCATTER_EN
            scatter_l <= scatter_mode;
`endif
            idx       <= 3'd0;
            busy      <= 1'b1;
            cur_x     <= gx[0];
            cur_y     <= gy[0];
            tgt_x     <= start_tx;
            tgt_y     <= start_ty;
            state     <= ST_ISSUE;
          end else begin
            state     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          dir   <= path.path_dir;
          state <= ST_MOVE;
        end
        ST_MOVE: begin
          if (idx == 3'(NUM_GHOSTS - 1)) begin
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            state      <= ST_DONE;
          end else begin
            idx   <= nxt_idx;
            cur_x <= load_x;
            cur_y <= load_y;
            tgt_x <= next_tx;
            tgt_y <= next_ty;
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          sweep_done <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          busy       <= 1'b0;
          sweep_done <= 1'b0;
          idx        <= 3'd0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Ghost position registers: only the indexed ghost changes, and only in MOVE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        gx[i] <= 5'(HOME_X + i);
        gy[i] <= 5'(HOME_Y);
      end
    end else if (state == ST_MOVE) begin
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        if (idx == 3'(i)) begin
          gx[i] <= step_x;
          gy[i] <= step_y;
        end
      end
    end
  end

  // Sticky caught flag; a catch in the same cycle as a clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      caught <= 1'b0;
    end else if ((state == ST_MOVE) && (step_x == pac_lx) && (step_y == pac_ly)) begin
      caught <= 1'b1;
    end else if (clear_caught) begin
      caught <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ghost_scheduler.sv
// tb_ghost_scheduler: scoreboard bench for ghost_scheduler. Stimulus pushes
// the expected end-of-sweep state into a queue; a negedge monitor checks the
// path finder inputs while busy and the ghost positions at each sweep_done.
module tb_ghost_scheduler;

  localparam int NG = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          move_tick = 1'b0;
  logic          clear_caught = 1'b0;
  logic [0:89]   map_v = '0;
  logic [4:0]    pac_x = 5'd0;
  logic [4:0]    pac_y = 5'd0;
  logic [5*NG-1:0] ghost_x;
  logic [5*NG-1:0] ghost_y;
  logic          busy;
  logic          sweep_done;
  logic          caught;

  // Path finder stub: fixed direction, or a direction derived from the current cell
  logic          use_fixed = 1'b1;
  logic [1:0]    fixed_dir = 2'b11;
  logic [1:0]    salt = 2'b00;

  ghost_scheduler_if path ();
  assign path.path_dir = use_fixed ? fixed_dir
                                   : 2'(path.path_cur_x + path.path_cur_y + {3'b000, salt});

  always #5 clk = ~clk;

  ghost_scheduler #(.NUM_GHOSTS(NG), .HOME_X(7), .HOME_Y(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .move_tick    (move_tick),
    .map          (map_v),
    .pac_x        (pac_x),
    .pac_y        (pac_y),
`ifdef GHOST_SCATTER_EN
    .scatter_mode (1'b0),
`endif
    .path         (path),
    .ghost_x      (ghost_x),
    .ghost_y      (ghost_y),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .caught       (caught),
    .clear_caught (clear_caught)
  );

  typedef struct packed {
    logic [5*NG-1:0] cx;
    logic [5*NG-1:0] cy;
    logic [5*NG-1:0] tx;
    logic [5*NG-1:0] ty;
    logic [5*NG-1:0] gx;
    logic [5*NG-1:0] gy;
    logic            caught;
  } exp_t;

  exp_t q[$];
  int   mx[NG];
  int   my[NG];
  logic m_caught;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int model_dir(input int x, input int y);
    if (use_fixed) return int'(fixed_dir);
    return (x + y + int'(salt)) % 4;
  endfunction

  // Reference step: plain integer arithmetic on the game rules
  task automatic model_step(input int x, input int y, input int d, input int tx, input int ty,
                            output int nx, output int ny);
    int cx, cy;
    nx = x;
    ny = y;
    cx = x;
    cy = y;
    if (x == tx && y == ty) return;
    case (d)
      0: cy = y - 1;
      1: cy = y + 1;
      2: cx = x - 1;
      default: cx = x + 1;
    endcase
    if (cx < 0 || cx > 17 || cy < 0 || cy > 4) return;
    if (map_v[cx + 18 * cy]) return;
    nx = cx;
    ny = cy;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NG; i++) begin
      mx[i] = 7 + i;
      my[i] = 2;
    end
    m_caught = 1'b0;
    q.delete();
  endtask

  function automatic logic [5*NG-1:0] pack_pos(input int v0, input int v1, input int v2, input int v3);
    logic [5*NG-1:0] r;
    r = {5'(v3), 5'(v2), 5'(v1), 5'(v0)};
    return r;
  endfunction

  // Compute one whole sweep with the model and push its expectation
  task automatic push_expect();
    exp_t e;
    int   px, py, nx, ny;
    px = int'(pac_x);
    py = int'(pac_y);
    for (int g = 0; g < NG; g++) begin
      e.cx[5*g +: 5] = 5'(mx[g]);
      e.cy[5*g +: 5] = 5'(my[g]);
      e.tx[5*g +: 5] = 5'(px);
      e.ty[5*g +: 5] = 5'(py);
      model_step(mx[g], my[g], model_dir(mx[g], my[g]), px, py, nx, ny);
      mx[g] = nx;
      my[g] = ny;
      if (nx == px && ny == py) m_caught = 1'b1;
    end
    e.gx = pack_pos(mx[0], mx[1], mx[2], mx[3]);
    e.gy = pack_pos(my[0], my[1], my[2], my[3]);
    e.caught = m_caught;
    q.push_back(e);
  endtask

  // Monitor: path finder inputs while busy, full state at every sweep_done
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        if (q.size() == 0) begin
          fail_now("busy_without_tick");
        end else if (busy_cnt < 3 * NG) begin
          e = q[0];
          g = busy_cnt / 3;
          check("path_cur_x", 32'(path.path_cur_x), 32'(e.cx[5*g +: 5]));
          check("path_cur_y", 32'(path.path_cur_y), 32'(e.cy[5*g +: 5]));
          check("path_tgt_x", 32'(path.path_tgt_x), 32'(e.tx[5*g +: 5]));
          check("path_tgt_y", 32'(path.path_tgt_y), 32'(e.ty[5*g +: 5]));
        end else begin
          fail_now("busy_too_long");
        end
        busy_cnt++;
      end
      if (sweep_done) begin
        done_cnt++;
        if (q.size() == 0) begin
          fail_now("spurious_sweep_done");
        end else begin
          e = q.pop_front();
          check("busy_cycles", 32'(busy_cnt), 32'(3 * NG));
          check("busy_at_done", 32'(busy), 32'd0);
          check("ghost_x", 32'(ghost_x), 32'(e.gx));
          check("ghost_y", 32'(ghost_y), 32'(e.gy));
          check("caught", 32'(caught), 32'(e.caught));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One sweep; optional extra tick at cycle 5 and pacman scramble mid-sweep
  task automatic do_sweep(input bit extra_tick, input bit scramble);
    int n, start;
    @(negedge clk);
    start = done_cnt;
    push_expect();
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    n = 0;
    while (done_cnt == start && n < 60) begin
      if (n == 3 && extra_tick) move_tick = 1'b1;
      if (n == 4) move_tick = 1'b0;
      if (n == 2 && scramble) begin
        pac_x = 5'($urandom_range(0, 17));
        pac_y = 5'($urandom_range(0, 4));
      end
      @(negedge clk);
      n++;
    end
    move_tick = 1'b0;
    if (done_cnt == start) fail_now("sweep_timeout");
    repeat (extra_tick ? 20 : 2) @(negedge clk);
    if (extra_tick) check("one_done_per_tick", 32'(done_cnt - start), 32'd1);
  endtask

  initial begin
    logic [5*NG-1:0] want;
    int start;

    // 1. reset state
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ghost_x", 32'(ghost_x), 32'(pack_pos(7, 8, 9, 10)));
    check("rst_ghost_y", 32'(ghost_y), 32'(pack_pos(2, 2, 2, 2)));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_caught", 32'(caught), 32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);
    check("rst_path_cur", 32'({path.path_cur_x, path.path_cur_y}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2. open map, chase right towards (15,2); pacman moves mid-sweep
    pac_x = 5'd15; pac_y = 5'd2; use_fixed = 1'b1; fixed_dir = 2'b11;
    do_sweep(1'b0, 1'b1);
    want = pack_pos(8, 9, 10, 11);
    check("t2_ghost_x", 32'(ghost_x), 32'(want));

    // 3. wall at cell (11,2) blocks ghost 3
    apply_reset();
    map_v[47] = 1'b1;
    pac_x = 5'd15; pac_y = 5'd2;
    do_sweep(1'b0, 1'b0);
    want = pack_pos(8, 9, 10, 10);
    check("t3_ghost_x", 32'(ghost_x), 32'(want));
    map_v = '0;

    // 4. up three times: y goes 2,1,0,0 without wrapping
    apply_reset();
    pac_x = 5'd0; pac_y = 5'd0; fixed_dir = 2'b00;
    repeat (3) do_sweep(1'b0, 1'b0);
    check("t4_ghost_y", 32'(ghost_y), 32'd0);

    // 5. caught set by ghost 3, survives a sweep, cleared by a pulse
    apply_reset();
    pac_x = 5'd11; pac_y = 5'd2; fixed_dir = 2'b11;
    do_sweep(1'b0, 1'b0);
    check("t5_caught_set", 32'(caught), 32'd1);
    do_sweep(1'b0, 1'b0);
    check("t5_caught_sticky", 32'(caught), 32'd1);
    clear_caught = 1'b1;
    @(negedge clk);
    clear_caught = 1'b0;
    m_caught = 1'b0;
    check("t5_caught_clear", 32'(caught), 32'd0);

    // 6. tick while busy ignored; then reset mid-sweep aborts
    apply_reset();
    pac_x = 5'd15; pac_y = 5'd2;
    do_sweep(1'b1, 1'b0);
    @(negedge clk);
    start = done_cnt;
    push_expect();
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_abort_ghost_x", 32'(ghost_x), 32'(pack_pos(7, 8, 9, 10)));
    check("t6_abort_ghost_y", 32'(ghost_y), 32'(pack_pos(2, 2, 2, 2)));
    check("t6_abort_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_done_after_abort", 32'(done_cnt - start), 32'd0);

    // Random phase: random walls, pacman, direction source and clears
    for (int s = 0; s < 30; s++) begin
      if (s % 5 == 0) begin
        for (int b = 0; b < 90; b++) map_v[b] = ($urandom_range(0, 7) == 0);
      end
      pac_x = 5'($urandom_range(0, 17));
      pac_y = 5'($urandom_range(0, 4));
      use_fixed = ($urandom_range(0, 2) == 0);
      fixed_dir = 2'($urandom_range(0, 3));
      salt = 2'($urandom_range(0, 3));
      do_sweep(1'b0, ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 3) == 0) begin
        clear_caught = 1'b1;
        @(negedge clk);
        clear_caught = 1'b0;
        m_caught = 1'b0;
        check("rand_clear", 32'(caught), 32'd0);
      end
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
